// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM arbiter slice.
package ppu_pkg;

  typedef enum logic [1:0] {SRC_NONE, SRC_BG, SRC_SPR, SRC_CPU} arb_src_t;

  localparam int unsigned PPU_ADDR_W = 14;
  localparam logic [PPU_ADDR_W-1:0] CHR_TOP = 14'h2000;

endpackage

// File: rtl/ppu_arb_pick.sv
// Combinational priority picker for the three VRAM requesters.
// Rendering favours BG > SPR > CPU; vblank/idle favours CPU > BG > SPR.
module ppu_arb_pick
  import ppu_pkg::*;
(
  input  logic     bg_req,
  input  logic     spr_req,
  input  logic     cpu_req,
  input  logic     rendering,
  input  logic     starve,
  output arb_src_t winner
);

  always_comb begin
    winner = SRC_NONE;
    // A starving CPU jumps the render queue even while rendering.
    if (cpu_req && (!rendering || starve)) begin
      winner = SRC_CPU;
    end else if (bg_req) begin
      winner = SRC_BG;
    end else if (spr_req) begin
      winner = SRC_SPR;
    end else if (cpu_req) begin
      winner = SRC_CPU;
    end
  end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Shares the single PPU VRAM/CHR port among BG fetch, sprite fetch and CPU $2007 access.
// Optional CPU starvation guard enabled by defining PPU_ARB_STARVE_GUARD_EN.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int unsigned ADDR_W       = PPU_ADDR_W,
  parameter bit          CHR_WRITABLE = 1'b0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              PPU_SLOW_CLOCK,
  input  logic              RST_N,
  input  logic              RENDERING,
  input  logic              BG_REQ,
  input  logic [ADDR_W-1:0] BG_ADDR,
  output logic              BG_GNT,
  output logic              BG_RVALID,
  input  logic              SPR_REQ,
  input  logic [ADDR_W-1:0] SPR_ADDR,
  output logic              SPR_GNT,
  output logic              SPR_RVALID,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [7:0]        CPU_WDATA,
  output logic              CPU_GNT,
  output logic              CPU_RVALID,
  output logic              CPU_BUSY,
  output logic [7:0]        RDATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  input  logic [7:0]        MEM_RDATA
);

`ifdef PPU_ARB_STARVE_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  arb_src_t          winner_raw;
  arb_src_t          winner;
  arb_src_t          tag_q;
  logic [3:0]        starve_cnt_q;
  logic              starve;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_mux;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;
  logic              cpu_wr;
  logic              chr_drop;
  logic              issue;

  assign starve = GuardEn && ({28'd0, starve_cnt_q} >= STARVE_LIMIT);

  ppu_arb_pick u_pick (
    .bg_req    (BG_REQ),
    .spr_req   (SPR_REQ),
    .cpu_req   (CPU_REQ),
    .rendering (RENDERING),
    .starve    (starve),
    .winner    (winner_raw)
  );

  // Nothing is granted while reset is held.
  assign winner = RST_N ? winner_raw : SRC_NONE;

  assign BG_GNT   = (winner == SRC_BG);
  assign SPR_GNT  = (winner == SRC_SPR);
  assign CPU_GNT  = (winner == SRC_CPU);
  assign CPU_BUSY = CPU_REQ & ~CPU_GNT;

  assign cpu_wr   = CPU_GNT && CPU_WE;
  // Writes into CHR ROM are acknowledged but never reach memory.
  assign chr_drop = cpu_wr && !CHR_WRITABLE && (CPU_ADDR < ADDR_W'(CHR_TOP));
  assign issue    = (winner != SRC_NONE) && !chr_drop;

  always_comb begin
    addr_mux = addr_q;
    unique case (winner)
      SRC_BG:  addr_mux = BG_ADDR;
      SRC_SPR: addr_mux = SPR_ADDR;
      SRC_CPU: addr_mux = CPU_ADDR;
      default: addr_mux = addr_q;
    endcase
  end

  assign MEM_EN    = issue;
  assign MEM_WE    = cpu_wr && !chr_drop;
  assign MEM_ADDR  = issue ? addr_mux : addr_q;
  assign MEM_WDATA = MEM_WE ? CPU_WDATA : wdata_q;

  always_ff @(posedge PPU_SLOW_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      tag_q        <= SRC_NONE;
      rdata_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (issue) begin
        addr_q <= addr_mux;
      end
      if (MEM_WE) begin
        wdata_q <= CPU_WDATA;
      end
      tag_q <= (issue && !MEM_WE) ? winner : SRC_NONE;
      if (tag_q != SRC_NONE) begin
        rdata_q <= MEM_RDATA;
      end
      if (!CPU_REQ || CPU_GNT) begin
        starve_cnt_q <= '0;
      end else if (GuardEn && CPU_BUSY && (starve_cnt_q != 4'hF)) begin
        starve_cnt_q <= starve_cnt_q + 4'd1;
      end
    end
  end

  // The memory's output register is the data register on the return cycle; rdata_q holds it after.
  assign RDATA      = (tag_q != SRC_NONE) ? MEM_RDATA : rdata_q;
  assign BG_RVALID  = (tag_q == SRC_BG);
  assign SPR_RVALID = (tag_q == SRC_SPR);
  assign CPU_RVALID = (tag_q == SRC_CPU);

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed self-checking bench for ppu_vram_arbiter with a synchronous VRAM model.
// Starvation checks follow PPU_ARB_STARVE_GUARD_EN when it is defined for the build.
module tb_ppu_vram_arbiter;

  logic        PPU_SLOW_CLOCK = 1'b0;
  logic        RST_N;
  logic        RENDERING;
  logic        BG_REQ;
  logic [13:0] BG_ADDR;
  logic        BG_GNT;
  logic        BG_RVALID;
  logic        SPR_REQ;
  logic [13:0] SPR_ADDR;
  logic        SPR_GNT;
  logic        SPR_RVALID;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [13:0] CPU_ADDR;
  logic [7:0]  CPU_WDATA;
  logic        CPU_GNT;
  logic        CPU_RVALID;
  logic        CPU_BUSY;
  logic [7:0]  RDATA;
  logic        MEM_EN;
  logic        MEM_WE;
  logic [13:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;

  int compared   = 0;
  int mismatched = 0;

  always #5 PPU_SLOW_CLOCK = ~PPU_SLOW_CLOCK;

  ppu_vram_arbiter dut (
    .PPU_SLOW_CLOCK (PPU_SLOW_CLOCK),
    .RST_N          (RST_N),
    .RENDERING      (RENDERING),
    .BG_REQ         (BG_REQ),
    .BG_ADDR        (BG_ADDR),
    .BG_GNT         (BG_GNT),
    .BG_RVALID      (BG_RVALID),
    .SPR_REQ        (SPR_REQ),
    .SPR_ADDR       (SPR_ADDR),
    .SPR_GNT        (SPR_GNT),
    .SPR_RVALID     (SPR_RVALID),
    .CPU_REQ        (CPU_REQ),
    .CPU_WE         (CPU_WE),
    .CPU_ADDR       (CPU_ADDR),
    .CPU_WDATA      (CPU_WDATA),
    .CPU_GNT        (CPU_GNT),
    .CPU_RVALID     (CPU_RVALID),
    .CPU_BUSY       (CPU_BUSY),
    .RDATA          (RDATA),
    .MEM_EN         (MEM_EN),
    .MEM_WE         (MEM_WE),
    .MEM_ADDR       (MEM_ADDR),
    .MEM_WDATA      (MEM_WDATA),
    .MEM_RDATA      (MEM_RDATA)
  );

  // Unwritten locations read as a fixed pattern: a[7:0] ^ 8'h5A ^ a[13:8].
  function automatic logic [7:0] mem_init(input logic [13:0] a);
    return a[7:0] ^ 8'h5A ^ {2'b00, a[13:8]};
  endfunction

  logic [7:0] mem [16384];
  bit         wr_mask [16384];
  logic [7:0] mem_rdata_r;

  always @(posedge PPU_SLOW_CLOCK) begin
    if (MEM_EN) begin
      if (MEM_WE) begin
        mem[MEM_ADDR]     <= MEM_WDATA;
        wr_mask[MEM_ADDR] <= 1'b1;
      end else begin
        mem_rdata_r <= wr_mask[MEM_ADDR] ? mem[MEM_ADDR] : mem_init(MEM_ADDR);
      end
    end
  end
  assign MEM_RDATA = mem_rdata_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge PPU_SLOW_CLOCK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic exp_cpu;
    RST_N = 1'b0; RENDERING = 1'b0;
    BG_REQ = 1'b0; BG_ADDR = '0; SPR_REQ = 1'b0; SPR_ADDR = '0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;

    // Reset state, with a request present that must not be granted.
    #3;
    BG_REQ = 1'b1; BG_ADDR = 14'h1234;
    settle();
    check("rst_bg_gnt", BG_GNT, 1'b0);
    check("rst_mem_en", MEM_EN, 1'b0);
    check("rst_mem_we", MEM_WE, 1'b0);
    check("rst_mem_addr", MEM_ADDR, 14'h0000);
    check("rst_mem_wdata", MEM_WDATA, 8'h00);
    check("rst_rdata", RDATA, 8'h00);
    check("rst_rvalid", {BG_RVALID, SPR_RVALID, CPU_RVALID}, 3'b000);
    BG_REQ = 1'b0;
    cyc();
    RST_N = 1'b1;
    cyc();

    // Reset mid-read: BG read issued, reset in the next cycle.
    RENDERING = 1'b1; BG_REQ = 1'b1; BG_ADDR = 14'h1010;
    settle();
    check("mid_bg_gnt", BG_GNT, 1'b1);
    check("mid_mem_addr", MEM_ADDR, 14'h1010);
    cyc();
    BG_REQ = 1'b0; RST_N = 1'b0;
    settle();
    check("mid_rst_bg_rvalid", BG_RVALID, 1'b0);
    cyc();
    RST_N = 1'b1;
    settle();
    check("mid_rel_bg_rvalid", BG_RVALID, 1'b0);
    check("mid_rel_rdata", RDATA, 8'h00);
    cyc();
    settle();
    check("mid_rel2_bg_rvalid", BG_RVALID, 1'b0);
    check("mid_rel2_rdata", RDATA, 8'h00);

    // Rendering: BG, SPR and CPU together -> BG, SPR, CPU.
    cyc();
    RENDERING = 1'b1;
    BG_REQ = 1'b1;  BG_ADDR = 14'h0100;
    SPR_REQ = 1'b1; SPR_ADDR = 14'h0200;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h2400;
    settle();
    check("r1_gnts", {BG_GNT, SPR_GNT, CPU_GNT}, 3'b100);
    check("r1_cpu_busy", CPU_BUSY, 1'b1);
    check("r1_mem_addr", MEM_ADDR, 14'h0100);
    check("r1_mem_en", MEM_EN, 1'b1);
    cyc();
    BG_REQ = 1'b0;
    settle();
    check("r2_gnts", {BG_GNT, SPR_GNT, CPU_GNT}, 3'b010);
    check("r2_mem_addr", MEM_ADDR, 14'h0200);
    check("r2_rvalid", {BG_RVALID, SPR_RVALID, CPU_RVALID}, 3'b100);
    check("r2_rdata", RDATA, 8'h5B);
    cyc();
    SPR_REQ = 1'b0;
    settle();
    check("r3_gnts", {BG_GNT, SPR_GNT, CPU_GNT}, 3'b001);
    check("r3_mem_addr", MEM_ADDR, 14'h2400);
    check("r3_rvalid", {BG_RVALID, SPR_RVALID, CPU_RVALID}, 3'b010);
    check("r3_rdata", RDATA, 8'h58);
    cyc();
    CPU_REQ = 1'b0;
    settle();
    check("r4_mem_en", MEM_EN, 1'b0);
    check("r4_rvalid", {BG_RVALID, SPR_RVALID, CPU_RVALID}, 3'b001);
    check("r4_rdata", RDATA, 8'h7E);
    cyc();
    settle();
    check("r5_rvalid", {BG_RVALID, SPR_RVALID, CPU_RVALID}, 3'b000);
    check("r5_rdata_hold", RDATA, 8'h7E);
    check("r5_addr_hold", MEM_ADDR, 14'h2400);

    // Vblank: CPU beats BG.
    cyc();
    RENDERING = 1'b0;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h2000;
    BG_REQ = 1'b1;  BG_ADDR = 14'h1000;
    settle();
    check("v1_gnts", {BG_GNT, SPR_GNT, CPU_GNT}, 3'b001);
    check("v1_cpu_busy", CPU_BUSY, 1'b0);
    cyc();
    CPU_REQ = 1'b0;
    settle();
    check("v2_cpu_rvalid", CPU_RVALID, 1'b1);
    check("v2_rdata", RDATA, 8'h7A);
    check("v2_bg_gnt", BG_GNT, 1'b1);
    cyc();
    BG_REQ = 1'b0;
    settle();
    check("v3_bg_rvalid", BG_RVALID, 1'b1);
    check("v3_rdata", RDATA, 8'h4A);

    // CHR protect: write to $0005 dropped, write to $23C0 lands.
    cyc();
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 14'h0005; CPU_WDATA = 8'hAB;
    settle();
    check("w1_cpu_gnt", CPU_GNT, 1'b1);
    check("w1_mem_en", MEM_EN, 1'b0);
    check("w1_mem_we", MEM_WE, 1'b0);
    cyc();
    CPU_REQ = 1'b0;
    settle();
    check("w1_no_rvalid", CPU_RVALID, 1'b0);
    cyc();
    CPU_REQ = 1'b1; CPU_WE = 1'b0;
    cyc();
    CPU_REQ = 1'b0;
    settle();
    check("w1_readback", RDATA, 8'h5F);
    cyc();
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 14'h23C0; CPU_WDATA = 8'hAB;
    settle();
    check("w2_cpu_gnt", CPU_GNT, 1'b1);
    check("w2_mem_we", MEM_WE, 1'b1);
    check("w2_mem_en", MEM_EN, 1'b1);
    check("w2_mem_addr", MEM_ADDR, 14'h23C0);
    check("w2_mem_wdata", MEM_WDATA, 8'hAB);
    cyc();
    CPU_REQ = 1'b0;
    settle();
    check("w2_no_rvalid", CPU_RVALID, 1'b0);
    cyc();
    CPU_REQ = 1'b1; CPU_WE = 1'b0;
    cyc();
    CPU_REQ = 1'b0;
    settle();
    check("w2_readback", RDATA, 8'hAB);

    // Rendering with BG hammering and a CPU read pending.
    cyc();
    RENDERING = 1'b1;
    BG_REQ = 1'b1;  BG_ADDR = 14'h0040;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h2010;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
`ifdef PPU_ARB_STARVE_GUARD_EN
      exp_cpu = (i == 8);
      if (i == 9) CPU_REQ = 1'b0;
      settle();
      check("st_cpu_gnt", CPU_GNT, exp_cpu);
      check("st_bg_gnt", BG_GNT, ~exp_cpu);
`else
      exp_cpu = 1'b0;
      settle();
      check("st_cpu_gnt", CPU_GNT, exp_cpu);
      check("st_cpu_busy", CPU_BUSY, 1'b1);
`endif
    end
    cyc();
    BG_REQ = 1'b0; CPU_REQ = 1'b0;
    settle();
    check("st_last_bg_rvalid", BG_RVALID, 1'b1);
    check("st_last_rdata", RDATA, 8'h1A);

    // Idle cycles.
    for (int i = 0; i < 2; i++) begin
      cyc();
      settle();
      check("idle_mem_en", MEM_EN, 1'b0);
      check("idle_rvalid", {BG_RVALID, SPR_RVALID, CPU_RVALID}, 3'b000);
      check("idle_rdata_hold", RDATA, 8'h1A);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ppu_vram_arbiter.md
Name: ppu_vram_arbiter

Overview:
- Shares the PPU's single 14-bit VRAM/CHR memory port among three requesters: background tile fetch, sprite slice fetch, and CPU $2007 (PPUDATA) access.
- Sits between the PPU render FSMs or register interface and the pattern/nametable memory.
- Issues at most one access per PPU_SLOW_CLOCK cycle and returns read data one cycle later, tagged to the requester that issued it.

Parameters:
- ADDR_W, 14, memory address width.
- CHR_WRITABLE, 0, when 0, CPU writes to $0000-$1FFF are dropped (CHR ROM).
- STARVE_LIMIT, 8, cycles a CPU request may wait before forced grant (used only with the optional feature).

Ports:
- PPU_SLOW_CLOCK  in  1  PPU clock, all logic on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- RENDERING  in  1  1 = visible scanline window; 0 = vblank or idle.
- BG_REQ  in  1  background fetch request.
- BG_ADDR  in  14  background fetch address.
- BG_GNT  out  1  background access issued this cycle.
- BG_RVALID  out  1  RDATA holds the background read.
- SPR_REQ  in  1  sprite fetch request.
- SPR_ADDR  in  14  sprite fetch address.
- SPR_GNT  out  1  sprite access issued this cycle.
- SPR_RVALID  out  1  RDATA holds the sprite read.
- CPU_REQ  in  1  CPU access request.
- CPU_WE  in  1  1 = write, 0 = read.
- CPU_ADDR  in  14  CPU access address.
- CPU_WDATA  in  8  CPU write data.
- CPU_GNT  out  1  CPU access issued this cycle.
- CPU_RVALID  out  1  RDATA holds the CPU read.
- CPU_BUSY  out  1  CPU_REQ pending and not granted.
- RDATA  out  8  registered read data, shared by all requesters.
- MEM_EN  out  1  memory access strobe.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  14  memory address.
- MEM_WDATA  out  8  memory write data.
- MEM_RDATA  in  8  synchronous read data, valid the cycle after MEM_EN.

Behaviour:
- Reset (RST_N=0, asynchronous): all GNT, RVALID, MEM_EN and MEM_WE are 0; MEM_ADDR, MEM_WDATA and RDATA are 0; tag = SRC_NONE; starve counter = 0. Reads outstanding at reset are discarded, so no RVALID follows reset release.
- Handshake:
  - A requester holds REQ, ADDR, WE and WDATA stable until its GNT.
  - GNT is a one-cycle pulse, combinational in the issue cycle.
  - REQ still high in the cycle after GNT counts as a new access, so back-to-back accesses run at one per cycle.
- Priority:
  - RENDERING=1: BG > SPR > CPU.
  - RENDERING=0: CPU > BG > SPR.
  - Priority uses the RENDERING value sampled in the same cycle, so a toggle takes effect immediately.
- Issue cycle:
  - MEM_EN=1; MEM_ADDR, MEM_WE and MEM_WDATA come from the winner, muxed combinationally.
  - MEM_WE=1 only for a CPU write.
  - No request pending: MEM_EN=0, MEM_WE=0, address holds its last value.
- Read return:
  - A registered tag (SRC_NONE/BG/SPR/CPU) records each read issue.
  - The next cycle: RDATA <= MEM_RDATA and exactly one RVALID is high for one cycle.
  - Writes set tag = SRC_NONE and produce no RVALID; CPU_GNT is write completion.
  - RDATA holds its value when no RVALID is asserted.
- CHR protect: with CHR_WRITABLE=0, a CPU write with CPU_ADDR < 'h2000 is still granted (CPU_GNT=1), but MEM_EN=0 and MEM_WE=0 that cycle, so the write is silently dropped.
- CPU_BUSY = CPU_REQ & ~CPU_GNT.
- Address bits above ADDR_W do not exist; no mirroring is done here. Mirroring belongs to the memory map.

Optional Feature:
- Macro: PPU_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments each cycle CPU_BUSY=1, saturating at 15.
  - When count >= STARVE_LIMIT, CPU wins the next arbitration over BG and SPR regardless of RENDERING.
  - The counter clears on CPU_GNT, and when CPU_REQ=0.
- Undefined: strict priority; during rendering the CPU may wait indefinitely.

Decomposition:
- Shared package ppu_pkg holds:
  - typedef enum logic [1:0] arb_src_t {SRC_NONE, SRC_BG, SRC_SPR, SRC_CPU};
  - PPU_ADDR_W = 14;
  - CHR_TOP = 'h2000.
- Sub-module ppu_arb_pick: purely combinational priority picker.
  - Inputs: the three REQs, RENDERING and the starve flag.
  - Output: the winning arb_src_t.
- The top level holds the tag register, RDATA register, starve counter and the memory mux.

Test Plan:
- Reset mid-read: BG read of 'h1010 issued, RST_N low in the next cycle -> BG_RVALID never asserts and RDATA=0 after release.
- RENDERING=1 with BG, SPR and CPU requesting on the same cycle -> grant order BG, SPR, CPU on three consecutive cycles; RVALIDs follow one cycle later with RDATA equal to memory at each address.
- RENDERING=0 with CPU read 'h2000 and BG read 'h1000 on the same cycle -> CPU_GNT first; CPU_RVALID next cycle with RDATA=mem['h2000]; BG granted the following cycle.
- CPU write 'hAB to 'h0005 with CHR_WRITABLE=0 -> CPU_GNT=1, MEM_WE=0, mem['h0005] unchanged; the same write to 'h23C0 -> MEM_WE=1 and mem['h23C0]='hAB.
- With PPU_ARB_STARVE_GUARD_EN, RENDERING=1, BG_REQ held high continuously and a CPU read pending -> CPU_GNT exactly 8 cycles after CPU_REQ rises, BG resumes the next cycle; without the macro -> CPU_GNT never asserts and CPU_BUSY stays 1.
- Idle cycles with no REQ -> MEM_EN=0, no RVALID, RDATA holds the previous value.
